// File: rtl/vc_input_buffer.sv
// vc_input_buffer: two-VC flit input buffer.
// Each virtual channel has its own circular FIFO of DEPTH entries. The
// downstream controller selects one VC at a time and may pop its head flit.
// The ready and valid flags come straight from the registered occupancy
// counts. There is no bypass, so a full VC never accepts a write in the
// cycle it is popped.
// Optional feature: define VC_CREDIT_EN to add the credit_out port. It
// carries a registered per-VC pulse in the cycle after each accepted pop.
module vc_input_buffer #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic              in_vc,
   input  logic [DATA_W-1:0] in_data,
   output logic [1:0]        in_ready,
   output logic              vc0_valid,
   output logic              vc1_valid,
   input  logic [1:0]        selected_vc,
   input  logic              out_pop,
   output logic [DATA_W-1:0] out_data,
   output logic              overflow_err
`ifdef VC_CREDIT_EN
   ,
   output logic [1:0]        credit_out
`endif
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};

   // Storage arrays; contents are deliberately not cleared by reset.
   logic [DATA_W-1:0] mem0_r [DEPTH];
   logic [DATA_W-1:0] mem1_r [DEPTH];

   logic [1:0][PTR_W-1:0] wr_ptr_r;
   logic [1:0][PTR_W-1:0] rd_ptr_r;
   logic [1:0][CNT_W-1:0] count_r;
   logic                  overflow_r;

   logic [1:0] in_ready_s;
   logic [1:0] not_empty_s;
   logic [1:0] wr_en_s;
   logic [1:0] pop_en_s;
   logic       drop_s;

   // Flow-control flags and the per-VC write/pop enables, from registered state only.
   always_comb begin
      in_ready_s  = 2'b00;
      not_empty_s = 2'b00;
      wr_en_s     = 2'b00;
      pop_en_s    = 2'b00;
      drop_s      = 1'b0;
      for (int v = 0; v < 2; v++) begin
         in_ready_s[v]  = (count_r[v] != FULL_CNT);
         not_empty_s[v] = (count_r[v] != ZERO_CNT);
      end
      wr_en_s[0]  = in_valid & ~in_vc & in_ready_s[0];
      wr_en_s[1]  = in_valid &  in_vc & in_ready_s[1];
      pop_en_s[0] = out_pop & (selected_vc == 2'b00) & not_empty_s[0];
      pop_en_s[1] = out_pop & (selected_vc == 2'b01) & not_empty_s[1];
      drop_s      = in_valid & ~in_ready_s[in_vc];
   end

   // Pointer and occupancy update per VC; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r <= '{default: {PTR_W{1'b0}}};
         rd_ptr_r <= '{default: {PTR_W{1'b0}}};
         count_r  <= '{default: {CNT_W{1'b0}}};
      end else begin
         for (int v = 0; v < 2; v++) begin
            if (wr_en_s[v]) begin
               wr_ptr_r[v] <= wr_ptr_r[v] + PTR_W'(1);
            end
            if (pop_en_s[v]) begin
               rd_ptr_r[v] <= rd_ptr_r[v] + PTR_W'(1);
            end
            case ({wr_en_s[v], pop_en_s[v]})
               2'b10:   count_r[v] <= count_r[v] + CNT_W'(1);
               2'b01:   count_r[v] <= count_r[v] - CNT_W'(1);
               default: count_r[v] <= count_r[v];
            endcase
         end
      end
   end

   // Payload storage writes at the selected VC's write pointer.
   always_ff @(posedge clk) begin
      if (wr_en_s[0]) begin
         mem0_r[wr_ptr_r[0]] <= in_data;
      end
      if (wr_en_s[1]) begin
         mem1_r[wr_ptr_r[1]] <= in_data;
      end
   end

   // Sticky overflow flag: set by any flit offered to a full VC, cleared only by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow_r <= 1'b0;
      end else if (drop_s) begin
         overflow_r <= 1'b1;
      end else begin
         overflow_r <= overflow_r;
      end
   end

   // Head-of-line mux for the selected VC; zero when nothing valid is selected.
   always_comb begin
      out_data = {DATA_W{1'b0}};
      case (selected_vc)
         2'b00: begin
            if (not_empty_s[0]) begin
               out_data = mem0_r[rd_ptr_r[0]];
            end else begin
               out_data = {DATA_W{1'b0}};
            end
         end
         2'b01: begin
            if (not_empty_s[1]) begin
               out_data = mem1_r[rd_ptr_r[1]];
            end else begin
               out_data = {DATA_W{1'b0}};
            end
         end
         default: out_data = {DATA_W{1'b0}};
      endcase
   end

   assign in_ready     = in_ready_s;
   assign vc0_valid    = not_empty_s[0];
   assign vc1_valid    = not_empty_s[1];
   assign overflow_err = overflow_r;

`ifdef VC_CREDIT_EN
   logic [1:0] credit_r;

   // Credit return: one registered pulse per accepted pop, in the following cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         credit_r <= 2'b00;
      end else begin
         credit_r <= pop_en_s;
      end
   end

   assign credit_out = credit_r;
`endif

endmodule

// File: tb/tb_vc_input_buffer.sv
// Directed testbench for vc_input_buffer (DATA_W=32, DEPTH=4).
// Define VC_CREDIT_EN on both the RTL and this bench to check credit_out.
module tb_vc_input_buffer;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_vc;
   logic [31:0] in_data;
   logic [1:0]  in_ready;
   logic        vc0_valid;
   logic        vc1_valid;
   logic [1:0]  selected_vc;
   logic        out_pop;
   logic [31:0] out_data;
   logic        overflow_err;
`ifdef VC_CREDIT_EN
   logic [1:0]  credit_out;
`endif

   int checks;
   int failures;

   vc_input_buffer #(.DATA_W(32), .DEPTH(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_vc        (in_vc),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .vc0_valid    (vc0_valid),
      .vc1_valid    (vc1_valid),
      .selected_vc  (selected_vc),
      .out_pop      (out_pop),
      .out_data     (out_data),
      .overflow_err (overflow_err)
`ifdef VC_CREDIT_EN
      ,
      .credit_out   (credit_out)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge, then settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid    = 1'b0;
      in_vc       = 1'b0;
      in_data     = 32'h0;
      selected_vc = 2'b11;
      out_pop     = 1'b0;
   endtask

   // Pulse reset between edges (the caller is at posedge+1).
   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      #2;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      #12;
      checks++;
      if (vc0_valid !== 1'b0 || vc1_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_valid: got %b%b expected 00", vc1_valid, vc0_valid);
      end
      checks++;
      if (in_ready !== 2'b11) begin
         failures++;
         $display("FAIL reset_ready: got %b expected 11", in_ready);
      end
      checks++;
      if (overflow_err !== 1'b0 || out_data !== 32'h0) begin
         failures++;
         $display("FAIL reset_err_data: got err=%b data=%h expected 0/0", overflow_err, out_data);
      end
`ifdef VC_CREDIT_EN
      checks++;
      if (credit_out !== 2'b00) begin
         failures++;
         $display("FAIL reset_credit: got %b expected 00", credit_out);
      end
`endif
      @(negedge clk);
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic_fifo();
      do_reset();
      in_valid = 1'b1; in_vc = 1'b0; in_data = 32'hA1;
      tick();
      checks++;
      if (vc0_valid !== 1'b1) begin
         failures++;
         $display("FAIL basic_valid_latency: got %b expected 1", vc0_valid);
      end
      in_data = 32'hA2;
      tick();
      in_valid = 1'b0; selected_vc = 2'b00;
      #1;
      checks++;
      if (out_data !== 32'hA1) begin
         failures++;
         $display("FAIL basic_head1: got %h expected 000000a1", out_data);
      end
      out_pop = 1'b1;
      tick();
      checks++;
      if (out_data !== 32'hA2) begin
         failures++;
         $display("FAIL basic_head2: got %h expected 000000a2", out_data);
      end
      tick();
      out_pop = 1'b0;
      checks++;
      if (vc0_valid !== 1'b0 || out_data !== 32'h0) begin
         failures++;
         $display("FAIL basic_drained: got valid=%b data=%h expected 0/0", vc0_valid, out_data);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      in_valid = 1'b1; in_vc = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         in_data = 32'h100 + 32'(i);
         tick();
         if (i == 4) begin
            checks++;
            if (in_ready !== 2'b01 || overflow_err !== 1'b0) begin
               failures++;
               $display("FAIL ovf_full: got ready=%b err=%b expected 01/0", in_ready, overflow_err);
            end
         end
      end
      in_valid = 1'b0;
      checks++;
      if (overflow_err !== 1'b1) begin
         failures++;
         $display("FAIL ovf_set: got %b expected 1", overflow_err);
      end
      tick();
      tick();
      checks++;
      if (overflow_err !== 1'b1 || in_ready !== 2'b01) begin
         failures++;
         $display("FAIL ovf_sticky: got err=%b ready=%b expected 1/01", overflow_err, in_ready);
      end
      selected_vc = 2'b01;
      for (int i = 1; i <= 4; i++) begin
         #1;
         checks++;
         if (out_data !== 32'h100 + 32'(i)) begin
            failures++;
            $display("FAIL ovf_order%0d: got %h expected %h", i, out_data, 32'h100 + 32'(i));
         end
         out_pop = 1'b1;
         tick();
`ifdef VC_CREDIT_EN
         checks++;
         if (credit_out !== 2'b10) begin
            failures++;
            $display("FAIL ovf_credit%0d: got %b expected 10", i, credit_out);
         end
`endif
         out_pop = 1'b0;
      end
      checks++;
      if (vc1_valid !== 1'b0 || in_ready !== 2'b11 || overflow_err !== 1'b1) begin
         failures++;
         $display("FAIL ovf_drained: got valid=%b ready=%b err=%b expected 0/11/1", vc1_valid, in_ready, overflow_err);
      end
   endtask

   task automatic test_full_push_pop();
      do_reset();
      in_valid = 1'b1; in_vc = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_data = 32'h10 + 32'(i);
         tick();
      end
      in_data = 32'h99; selected_vc = 2'b00; out_pop = 1'b1;
      tick();
      in_valid = 1'b0; out_pop = 1'b0;
      checks++;
      if (overflow_err !== 1'b1 || in_ready !== 2'b11 || out_data !== 32'h11) begin
         failures++;
         $display("FAIL fullpp_state: got err=%b ready=%b head=%h expected 1/11/00000011", overflow_err, in_ready, out_data);
      end
      for (int i = 1; i < 4; i++) begin
         #1;
         checks++;
         if (out_data !== 32'h10 + 32'(i)) begin
            failures++;
            $display("FAIL fullpp_order%0d: got %h expected %h", i, out_data, 32'h10 + 32'(i));
         end
         out_pop = 1'b1;
         tick();
         out_pop = 1'b0;
      end
      checks++;
      if (vc0_valid !== 1'b0) begin
         failures++;
         $display("FAIL fullpp_count3: got valid=%b expected 0 after 3 pops", vc0_valid);
      end
   endtask

   task automatic test_cross_vc();
      do_reset();
      in_valid = 1'b1; in_vc = 1'b0; in_data = 32'hC1;
      tick();
      in_data = 32'hC2;
      tick();
      in_vc = 1'b1; in_data = 32'hB1; selected_vc = 2'b00; out_pop = 1'b1;
      tick();
      in_valid = 1'b0; out_pop = 1'b0;
      checks++;
      if (vc0_valid !== 1'b1 || vc1_valid !== 1'b1 || out_data !== 32'hC2) begin
         failures++;
         $display("FAIL cross_state: got v0=%b v1=%b head=%h expected 1/1/000000c2", vc0_valid, vc1_valid, out_data);
      end
      selected_vc = 2'b10; out_pop = 1'b1;
      #1;
      checks++;
      if (out_data !== 32'h0) begin
         failures++;
         $display("FAIL cross_none_data: got %h expected 0", out_data);
      end
      tick();
      out_pop = 1'b0; selected_vc = 2'b00;
      #1;
      checks++;
      if (out_data !== 32'hC2 || overflow_err !== 1'b0) begin
         failures++;
         $display("FAIL cross_none_vc0: got %h err=%b expected 000000c2/0", out_data, overflow_err);
      end
      selected_vc = 2'b01;
      #1;
      checks++;
      if (out_data !== 32'hB1) begin
         failures++;
         $display("FAIL cross_none_vc1: got %h expected 000000b1", out_data);
      end
   endtask

   task automatic test_wrap_credit();
      int credit_pulses;
      credit_pulses = 0;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_vc = 1'b0; in_data = 32'hD0 + 32'(i);
         tick();
`ifdef VC_CREDIT_EN
         if (i > 0) begin
            checks++;
            if (credit_out !== 2'b00) begin
               failures++;
               $display("FAIL wrap_credit_width%0d: got %b expected 00", i, credit_out);
            end
         end
`endif
         in_valid = 1'b0; selected_vc = 2'b00;
         #1;
         checks++;
         if (out_data !== 32'hD0 + 32'(i)) begin
            failures++;
            $display("FAIL wrap_order%0d: got %h expected %h", i, out_data, 32'hD0 + 32'(i));
         end
         out_pop = 1'b1;
         tick();
         out_pop = 1'b0;
`ifdef VC_CREDIT_EN
         if (credit_out === 2'b01) credit_pulses++;
`endif
      end
      checks++;
      if (vc0_valid !== 1'b0) begin
         failures++;
         $display("FAIL wrap_empty: got %b expected 0", vc0_valid);
      end
`ifdef VC_CREDIT_EN
      checks++;
      if (credit_pulses != 10) begin
         failures++;
         $display("FAIL wrap_credit_count: got %0d expected 10", credit_pulses);
      end
`endif
   endtask

   task automatic test_reset_midstream();
      do_reset();
      in_valid = 1'b1; in_vc = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 32'hE0 + 32'(i);
         tick();
      end
      in_valid = 1'b0; selected_vc = 2'b01;
      #1;
      checks++;
      if (out_data !== 32'hE0 || vc1_valid !== 1'b1) begin
         failures++;
         $display("FAIL mid_pre: got %h valid=%b expected 000000e0/1", out_data, vc1_valid);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (vc1_valid !== 1'b0 || in_ready !== 2'b11 || out_data !== 32'h0) begin
         failures++;
         $display("FAIL mid_async: got valid=%b ready=%b data=%h expected 0/11/0", vc1_valid, in_ready, out_data);
      end
      reset = 1'b0;
      out_pop = 1'b1;
      tick();
      out_pop = 1'b0;
      checks++;
      if (vc1_valid !== 1'b0 || overflow_err !== 1'b0 || in_ready !== 2'b11) begin
         failures++;
         $display("FAIL empty_pop: got valid=%b err=%b ready=%b expected 0/0/11", vc1_valid, overflow_err, in_ready);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_basic_fifo();
      test_overflow();
      test_full_push_pop();
      test_cross_vc();
      test_wrap_credit();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vc_input_buffer.md
VC_INPUT_BUFFER -- requirements
Module: vc_input_buffer

Interface
REQ-001 Parameter DATA_W, default 32, flit payload width in bits.
REQ-002 Parameter DEPTH, default 4, entries per virtual-channel FIFO; legal values are powers of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream flit present this cycle.
REQ-006 in_vc  input  1  target VC of the incoming flit (0 = VC0, 1 = VC1).
REQ-007 in_data  input  DATA_W  incoming flit payload.
REQ-008 in_ready  output  2  per-VC not-full flag; bit v high means VC v can accept a flit.
REQ-009 vc0_valid  output  1  VC0 FIFO non-empty.
REQ-010 vc1_valid  output  1  VC1 FIFO non-empty.
REQ-011 selected_vc  input  2  VC chosen by the downstream controller: 2'b00 = VC0, 2'b01 = VC1, 2'b10/2'b11 = none.
REQ-012 out_pop  input  1  downstream consumes the head of the selected VC this cycle.
REQ-013 out_data  output  DATA_W  head flit of the selected VC.
REQ-014 overflow_err  output  1  sticky flag; a flit was offered to a full VC.
REQ-015 credit_out  output  2  per-VC credit-return pulse; present only when VC_CREDIT_EN is defined.

Function
REQ-016 The block SHALL keep two independent circular FIFOs (VC0, VC1), each DEPTH x DATA_W, with read/write pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0, and an occupancy count of log2(DEPTH)+1 bits.
REQ-017 A write to VC v SHALL occur when in_valid=1, in_vc=v and in_ready[v]=1; the flit is stored at the VC v write pointer.
REQ-018 in_ready[v] SHALL equal (count[v] != DEPTH), derived from registered state only; a pop in the same cycle SHALL NOT make a full VC accept a write (no bypass).
REQ-019 in_valid=1 with in_ready[in_vc]=0 SHALL drop the flit, leave that FIFO unchanged, and set overflow_err=1 on the next edge; overflow_err stays 1 until reset.
REQ-020 vcN_valid SHALL equal (count[N] != 0), taken from registered state; write-to-valid latency is one cycle.
REQ-021 out_data SHALL be combinational: the head entry of VC0 when selected_vc=2'b00, the head entry of VC1 when selected_vc=2'b01, otherwise all zeros; it is also all zeros when the selected VC is empty.
REQ-022 A pop SHALL occur when out_pop=1, selected_vc is 2'b00 or 2'b01, and that VC is non-empty; the read pointer then advances.
REQ-023 out_pop on an empty VC, or with selected_vc 2'b10/2'b11, SHALL be ignored with no state change and no error.
REQ-024 A write and a pop on the same VC in the same cycle SHALL both take effect, leaving the count unchanged; when the VC is empty, the pop is ignored and the write proceeds.
REQ-025 A write to one VC and a pop from the other VC in the same cycle SHALL both take effect independently.
REQ-026 Flits SHALL leave each VC in strict arrival order; there is no ordering between VCs.

Reset
REQ-027 While reset=1, regardless of clk: all pointers and counts are 0, vc0_valid=0, vc1_valid=0, in_ready=2'b11, overflow_err=0, credit_out=2'b00.
REQ-028 Reset asserted mid-operation SHALL discard all buffered flits; storage array contents are not cleared, and out_data reads 0 because both VCs are empty.

Configuration
REQ-029 With the macro VC_CREDIT_EN defined, credit_out[v] SHALL be a registered one-cycle pulse in the cycle after each accepted pop from VC v; it is 0 otherwise.
REQ-030 With VC_CREDIT_EN undefined, the credit_out port and its logic SHALL be absent; flow control then relies on in_ready only.

Verification
REQ-031 Reset, then write A1 and A2 to VC0 on consecutive cycles -> vc0_valid=1 one cycle after A1; selected_vc=00 with two pops -> out_data A1 then A2, vc0_valid=0 after the second pop.
REQ-032 DEPTH=4: write 5 flits to VC1 back-to-back -> in_ready[1]=0 after the 4th, 5th flit dropped, overflow_err=1 and sticky; 4 pops return flits 1-4 in order.
REQ-033 VC0 full, same-cycle write to VC0 and pop of VC0 -> pop accepted, write dropped, overflow_err=1, count=3.
REQ-034 Write B1 to VC1 while popping VC0 (count 2) in one cycle -> VC0 count=1, VC1 count=1; out_pop with selected_vc=2'b10 -> no change.
REQ-035 Push/pop 10 flits through VC0 (pointer wrap) -> FIFO order preserved; with VC_CREDIT_EN, 10 single-cycle credit_out[0] pulses, each one cycle after its pop.
REQ-036 Assert reset mid-stream with 3 flits in VC1 -> vc1_valid=0, in_ready=2'b11, out_data=0 immediately, without waiting for a clock edge.
